// File: rtl/router_fifo_pkg.sv
// Shared constants, header field positions and entry type for the router FIFO slice.
package router_pkg;

  localparam int unsigned FIFO_DEPTH = 16;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned PTR_W      = 5;
  localparam int unsigned IDX_W      = PTR_W - 1;
  localparam int unsigned CNT_W      = 7;

  localparam int unsigned LEN_MSB  = 7;
  localparam int unsigned LEN_LSB  = 2;
  localparam int unsigned ADDR_MSB = 1;
  localparam int unsigned ADDR_LSB = 0;

  typedef struct packed {
    logic              hdr;
    logic [DATA_W-1:0] data;
  } entry_t;

  // Bytes still to come after a header: payload length plus one parity byte.
  function automatic logic [CNT_W-1:0] hdr_count(input logic [DATA_W-1:0] b);
    return CNT_W'(b[LEN_MSB:LEN_LSB]) + CNT_W'(1);
  endfunction

endpackage

// File: rtl/router_fifo_mem.sv
// 16x9 storage array: synchronous write and clear, asynchronous read.
module router_fifo_mem
  import router_pkg::*;
(
  input  logic             clock,
  input  logic             clear,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  entry_t           wdata,
  input  logic [IDX_W-1:0] raddr,
  output entry_t           rdata
);

  entry_t mem [FIFO_DEPTH];

  always_ff @(posedge clock) begin
    if (clear) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/router_fifo.sv
// Router packet FIFO: pointers, flags, packet counter and output register.
// Define ROUTER_FIFO_TRISTATE_EN to idle data_out at all-Z instead of 8'h00.
module router_fifo
  import router_pkg::*;
(
  input  logic              clock,
  input  logic              resetn,
  input  logic              soft_reset,
  input  logic              write_enb,
  input  logic              read_enb,
  input  logic              lfd_state,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              full,
  output logic              empty
);

`ifdef ROUTER_FIFO_TRISTATE_EN
  localparam logic [DATA_W-1:0] IDLE = 'z;
`else
  localparam logic [DATA_W-1:0] IDLE = '0;
`endif

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_wr;
  logic             do_rd;
  logic             mem_we;
  logic             mem_clear;
  entry_t           wr_entry;
  entry_t           rd_entry;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) &&
                 (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]);

  assign do_wr = write_enb && !full;
  assign do_rd = read_enb && !empty;

  assign mem_clear = resetn || soft_reset;
  assign mem_we    = do_wr && !mem_clear;
  assign wr_entry  = '{hdr: lfd_state, data: data_in};

  router_fifo_mem u_mem (
    .clock (clock),
    .clear (mem_clear),
    .we    (mem_we),
    .waddr (wr_ptr[IDX_W-1:0]),
    .wdata (wr_entry),
    .raddr (rd_ptr[IDX_W-1:0]),
    .rdata (rd_entry)
  );

  always_ff @(posedge clock) begin
    if (resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      data_out <= '0;
    end else if (soft_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      data_out <= IDLE;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_rd) begin
        rd_ptr   <= rd_ptr + PTR_W'(1);
        data_out <= rd_entry.data;
        if (rd_entry.hdr) begin
          count <= hdr_count(rd_entry.data);
        end else if (count != '0) begin
          count <= count - CNT_W'(1);
        end
      end else if (count == '0) begin
        // Outside a packet the output falls back to idle.
        data_out <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_router_fifo.sv
// Self-checking bench for router_fifo: directed vector table, packet sequences, random traffic.
module tb_router_fifo;

`ifdef ROUTER_FIFO_TRISTATE_EN
  localparam logic [7:0] IDLE = 8'hzz;
`else
  localparam logic [7:0] IDLE = 8'h00;
`endif

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       soft_reset = 1'b0;
  logic       write_enb = 1'b0;
  logic       read_enb = 1'b0;
  logic       lfd_state = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       full;
  logic       empty;

  int errors = 0;
  int checks = 0;

  router_fifo dut (
    .clock      (clock),
    .resetn     (resetn),
    .soft_reset (soft_reset),
    .write_enb  (write_enb),
    .read_enb   (read_enb),
    .lfd_state  (lfd_state),
    .data_in    (data_in),
    .data_out   (data_out),
    .full       (full),
    .empty      (empty)
  );

  always #5 clock = ~clock;

  // Reference model: a queue of {header flag, byte} plus the remaining packet length.
  logic [8:0] q[$];
  int         m_cnt = 0;
  logic [7:0] m_dout = 8'h00;

  task automatic model_edge(input logic rst, srst, we, re, lfd, input logic [7:0] din);
    logic [8:0] e;
    bit rd_ok, wr_ok;
    if (rst) begin
      q.delete(); m_cnt = 0; m_dout = 8'h00;
    end else if (srst) begin
      q.delete(); m_cnt = 0; m_dout = IDLE;
    end else begin
      rd_ok = re && (q.size() != 0);
      wr_ok = we && (q.size() != 16);
      if (rd_ok) begin
        e = q.pop_front();
        m_dout = e[7:0];
        if (e[8]) m_cnt = int'(e[7:2]) + 1;
        else if (m_cnt > 0) m_cnt = m_cnt - 1;
      end else if (m_cnt == 0) begin
        m_dout = IDLE;
      end
      if (wr_ok) q.push_back({lfd, din});
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  task automatic check1(input string name, input logic act, exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp_v);
    end
  endtask

  task automatic drive(input logic rst, srst, we, re, lfd, input logic [7:0] din);
    @(negedge clock);
    resetn = rst; soft_reset = srst; write_enb = we; read_enb = re;
    lfd_state = lfd; data_in = din;
    @(posedge clock);
    #1;
  endtask

  // One model-checked cycle.
  task automatic step(input string tag, input logic rst, srst, we, re, lfd, input logic [7:0] din);
    drive(rst, srst, we, re, lfd, din);
    model_edge(rst, srst, we, re, lfd, din);
    check8({tag, ".data_out"}, data_out, m_dout);
    check1({tag, ".empty"}, empty, (q.size() == 0));
    check1({tag, ".full"}, full, (q.size() == 16));
  endtask

  typedef struct {
    logic       rst, srst, we, re, lfd;
    logic [7:0] din;
    logic [7:0] dout;
    logic       emp, ful;
  } vec_t;

  vec_t vt[13];

  initial begin
    vt[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
    vt[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h39, IDLE,  1'b0, 1'b0};
    vt[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hAA, IDLE,  1'b0, 1'b0};
    vt[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h39, 1'b0, 1'b0};
    vt[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h55, 8'hAA, 1'b0, 1'b0};
    vt[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hAA, 1'b0, 1'b0};
    vt[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h55, 1'b1, 1'b0};
    vt[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h55, 1'b1, 1'b0};
    vt[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hEE, IDLE,  1'b1, 1'b0};
    vt[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, IDLE,  1'b1, 1'b0};
    vt[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h77, IDLE,  1'b0, 1'b0};
    vt[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h77, 1'b1, 1'b0};
    vt[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, IDLE,  1'b1, 1'b0};

    for (int i = 0; i < 13; i++) begin
      drive(vt[i].rst, vt[i].srst, vt[i].we, vt[i].re, vt[i].lfd, vt[i].din);
      check8($sformatf("vec%0d.data_out", i), data_out, vt[i].dout);
      check1($sformatf("vec%0d.empty", i), empty, vt[i].emp);
      check1($sformatf("vec%0d.full", i), full, vt[i].ful);
    end

    // Full packet: header 0x39 (14 payload bytes), payload, parity.
    step("pkt.reset", 1, 0, 0, 0, 0, 8'h00);
    step("pkt.hdr", 0, 0, 1, 0, 1, 8'h39);
    for (int i = 0; i < 14; i++) step($sformatf("pkt.pay%0d", i), 0, 0, 1, 0, 0, 8'h10 + 8'(i));
    step("pkt.parity", 0, 0, 1, 0, 0, 8'hC3);
    check1("pkt.full_after_16", full, 1'b1);
    step("pkt.drop17", 0, 0, 1, 0, 0, 8'hFF);
    check8("pkt.rd_hdr", 8'h00, 8'h00 & data_out);
    step("pkt.rd0", 0, 0, 0, 1, 0, 8'h00);
    check8("pkt.hdr_out", data_out, 8'h39);
    for (int i = 1; i < 15; i++) step($sformatf("pkt.rd%0d", i), 0, 0, 0, 1, 0, 8'h00);
    step("pkt.rd15", 0, 0, 0, 1, 0, 8'h00);
    check8("pkt.parity_out", data_out, 8'hC3);
    check1("pkt.empty_end", empty, 1'b1);
    step("pkt.idle", 0, 0, 0, 0, 0, 8'h00);
    check8("pkt.idle_out", data_out, IDLE);

    // Simultaneous read/write while full, then while holding 5 words.
    for (int i = 0; i < 16; i++) step($sformatf("sim.fill%0d", i), 0, 0, 1, 0, (i == 0), 8'h20 + 8'(i));
    step("sim.rw_full", 0, 0, 1, 1, 0, 8'h99);
    check1("sim.full_dropped", full, 1'b0);
    step("sim.reset", 1, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 5; i++) step($sformatf("sim.five%0d", i), 0, 0, 1, 0, 0, 8'h40 + 8'(i));
    for (int i = 0; i < 4; i++) step($sformatf("sim.rw5_%0d", i), 0, 0, 1, 1, 0, 8'h50 + 8'(i));

    // Soft reset after 7 writes, then a fresh byte round-trips.
    step("soft.reset", 1, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 7; i++) step($sformatf("soft.w%0d", i), 0, 0, 1, 0, (i == 0), 8'h08 + 8'(i));
    step("soft.pulse", 0, 1, 1, 1, 0, 8'hEE);
    check1("soft.empty", empty, 1'b1);
    check8("soft.idle_out", data_out, IDLE);
    step("soft.w_new", 0, 0, 1, 0, 0, 8'h6B);
    step("soft.r_new", 0, 0, 0, 1, 0, 8'h00);
    check8("soft.new_byte", data_out, 8'h6B);

    // Wrap-around: three rounds of 10 writes then 10 reads.
    step("wrap.reset", 1, 0, 0, 0, 0, 8'h00);
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 10; i++) step($sformatf("wrap%0d.w%0d", r, i), 0, 0, 1, 0, 0, 8'(r * 16 + i + 1));
      for (int i = 0; i < 10; i++) step($sformatf("wrap%0d.r%0d", r, i), 0, 0, 0, 1, 0, 8'h00);
    end
    check1("wrap.empty_end", empty, 1'b1);

    // Reads while empty inside a packet leave data_out alone.
    step("emp.hdr", 0, 0, 1, 0, 1, 8'h39);
    step("emp.rd", 0, 0, 0, 1, 0, 8'h00);
    for (int i = 0; i < 3; i++) step($sformatf("emp.rd_empty%0d", i), 0, 0, 0, 1, 0, 8'h00);
    check8("emp.hold", data_out, 8'h39);

    // Random traffic against the model.
    step("rnd.reset", 1, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 3000; i++) begin
      logic rst, srst, we, re, lfd;
      rst  = ($urandom_range(0, 299) == 0);
      srst = ($urandom_range(0, 149) == 0);
      we   = ($urandom_range(0, 99) < ((i / 250) % 2 == 0 ? 70 : 35));
      re   = ($urandom_range(0, 99) < ((i / 250) % 2 == 0 ? 35 : 70));
      lfd  = ($urandom_range(0, 7) == 0);
      step($sformatf("rnd%0d", i), rst, srst, we, re, lfd, 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/router_fifo.md
ROUTER_FIFO -- requirements
Module: router_fifo

Interface
REQ-001 SHALL have port: clock  input  1  single clock; all state changes on its rising edge.
REQ-002 SHALL have port: resetn  input  1  reset, synchronous and active-high (asserted = 1), despite the name.
REQ-003 SHALL have port: soft_reset  input  1  synchronous active-high flush (packet timeout).
REQ-004 SHALL have port: write_enb  input  1  write request.
REQ-005 SHALL have port: read_enb  input  1  read request.
REQ-006 SHALL have port: lfd_state  input  1  marks the current data_in byte as a packet header.
REQ-007 SHALL have port: data_in  input  8  byte to write.
REQ-008 SHALL have port: data_out  output  8  registered read data.
REQ-009 SHALL have port: full  output  1  16 words stored.
REQ-010 SHALL have port: empty  output  1  0 words stored.

Function
REQ-011 SHALL provide 16 entries of 9 bits, each holding {lfd_state, data_in}.
REQ-012 SHALL use 5-bit write and read pointers: 4-bit index plus wrap bit.
REQ-013 SHALL write on a rising edge when write_enb=1 and full=0; a write while full is dropped.
REQ-014 SHALL read on a rising edge when read_enb=1 and empty=0; a read while empty is ignored and leaves data_out unchanged.
REQ-015 SHALL perform both operations in the same cycle when both are enabled, using the pre-edge flags; when full, only the read occurs; when empty, only the write occurs.
REQ-016 SHALL drive empty and full combinationally from the pointers: empty when pointers are equal; full when the indices are equal and the wrap bits differ.
REQ-017 SHALL update data_out on the read edge (1-cycle latency) with bits [7:0] of the entry read.
REQ-018 SHALL keep a 7-bit packet counter; on a read of an entry whose bit 8 is 1, it loads data[7:2]+1 (payload plus parity).
REQ-019 SHALL decrement the counter on a read of an entry whose bit 8 is 0, saturating at 0.
REQ-020 SHALL set data_out to the idle value on any edge with no read while the counter is 0; otherwise data_out holds.
REQ-021 SHALL let pointers wrap modulo 16 indices with the wrap bit toggling; no other overflow handling.

Reset
REQ-022 SHALL, with resetn=1: clear both pointers, clear the counter, clear all storage, and set data_out=0, empty=1, full=0.
REQ-023 SHALL give resetn priority over soft_reset, reads and writes.
REQ-024 SHALL, with soft_reset=1 (and resetn=0): clear the pointers, counter and storage, set data_out to the idle value, and ignore any read or write in that cycle.
REQ-025 SHALL apply reset mid-packet immediately on that edge; no partial packet survives.

Configuration
REQ-026 SHALL, with ROUTER_FIFO_TRISTATE_EN defined, use all-Z as the data_out idle value, for sharing the output bus.
REQ-027 SHALL, without ROUTER_FIFO_TRISTATE_EN, use 8'h00 as the idle value; all other behaviour is identical.

Structure
REQ-028 SHALL have a shared package router_pkg holding: FIFO_DEPTH=16, DATA_W=8, PTR_W=5, CNT_W=7, and the header field positions (len [7:2], addr [1:0]).
REQ-029 SHALL put the 16x9 storage array in one sub-module, router_fifo_mem; pointers, flags, counter and output register stay in router_fifo.

Verification
REQ-030 SHALL cover reset: resetn=1 for one cycle -> empty=1, full=0, data_out=0.
REQ-031 SHALL cover packet write then read:
- write header 8'h39 (lfd_state=1), then 14 payload bytes, then parity (16 writes) -> full=1 after the 16th;
- 17th write dropped;
- 16 reads -> 8'h39, payloads in order, parity, then empty=1;
- next idle edge -> data_out = idle value.
REQ-032 SHALL cover simultaneous read and write:
- while full -> only the read occurs, full drops to 0;
- while holding 5 words -> count unchanged, flags unchanged.
REQ-033 SHALL cover soft reset: soft_reset pulse after 7 writes -> empty=1, full=0, data_out = idle value; the next write/read returns the new byte.
REQ-034 SHALL cover wrap-around: 3 cycles of write-10/read-10 -> data returned in order, full never asserted, empty=1 at the end.
REQ-035 SHALL cover reads while empty: read_enb=1 with empty=1 -> data_out and pointers unchanged.
